// File: rtl/pool_pkg.sv
// pool_pkg: shared state encoding and field widths for the max-pooling sequencer
package pool_pkg;
  localparam int AW_DEF = 24;
  localparam int DW_DEF = 16;
  localparam int SIDE_W = 8;
  localparam int KER_W = 4;
  localparam int STR_W = 2;
  localparam int CH_W = 12;
  localparam int LEN_W = 8;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_START, S_READ, S_WAIT, S_WRITE, S_FIN} state_t;
endpackage

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: nested window/element counters with running input address adders
module pool_addr_gen import pool_pkg::*; #(
  parameter int AW = AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_init,
  input  logic              i_step,
  input  logic [SIDE_W-1:0] i_side,
  input  logic [KER_W-1:0]  i_kernel,
  input  logic [STR_W-1:0]  i_stride,
  input  logic [CH_W-1:0]   i_ch,
  input  logic [AW-1:0]     i_rp,
  output logic [AW-1:0]     o_addr,
  output logic              o_last_elem,
  output logic              o_last_win
);
  localparam int PW = SIDE_W + 2;
  logic [KER_W-1:0] r_kx, r_ky;
  logic [CH_W-1:0] r_c;
  logic [PW-1:0] r_ox_pos, r_oy_pos;
  logic [AW-1:0] r_row, r_col, r_win, r_ky_base, r_addr;
  logic [AW-1:0] w_ch, w_sch, w_srp, w_nwin;
  logic w_kx_end, w_ky_end, w_c_end, w_row_end, w_map_end;
  // end-of-loop tests and stride-scaled pitches (stride is 1..3, so a shift-add suffices)
  always_comb begin
    w_ch = AW'(i_ch);
    w_sch = (i_stride[1] ? w_ch << 1 : '0) + (i_stride[0] ? w_ch : '0);
    w_srp = (i_stride[1] ? i_rp << 1 : '0) + (i_stride[0] ? i_rp : '0);
    w_kx_end = r_kx == i_kernel - KER_W'(1);
    w_ky_end = r_ky == i_kernel - KER_W'(1);
    w_c_end = r_c == i_ch - CH_W'(1);
    w_row_end = r_ox_pos + PW'(i_stride) + PW'(i_kernel) > PW'(i_side);
    w_map_end = r_oy_pos + PW'(i_stride) + PW'(i_kernel) > PW'(i_side);
    w_nwin = !w_c_end ? r_win + AW'(1) : !w_row_end ? r_col + w_sch : r_row + w_srp;
  end
  assign o_addr = r_addr;
  assign o_last_elem = w_kx_end & w_ky_end;
  assign o_last_win = w_c_end & w_row_end & w_map_end;
  // advance kx, then ky, then the window (c, ox, oy) on each step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kx <= '0; r_ky <= '0; r_c <= '0; r_ox_pos <= '0; r_oy_pos <= '0;
      r_row <= '0; r_col <= '0; r_win <= '0; r_ky_base <= '0; r_addr <= '0;
    end else if (i_init) begin
      r_kx <= '0; r_ky <= '0; r_c <= '0; r_ox_pos <= '0; r_oy_pos <= '0;
      r_row <= '0; r_col <= '0; r_win <= '0; r_ky_base <= '0; r_addr <= '0;
    end else if (i_step) begin
      r_kx <= w_kx_end ? '0 : r_kx + KER_W'(1);
      if (!w_kx_end) begin
        r_addr <= r_addr + w_ch;
      end else if (!w_ky_end) begin
        r_ky <= r_ky + KER_W'(1);
        r_ky_base <= r_ky_base + i_rp;
        r_addr <= r_ky_base + i_rp;
      end else begin
        r_ky <= '0;
        r_c <= w_c_end ? '0 : r_c + CH_W'(1);
        r_win <= w_nwin;
        r_ky_base <= w_nwin;
        r_addr <= w_nwin;
        if (w_c_end && !w_row_end) begin
          r_ox_pos <= r_ox_pos + PW'(i_stride);
          r_col <= w_nwin;
        end
        if (w_c_end && w_row_end) begin
          r_ox_pos <= '0;
          r_oy_pos <= r_oy_pos + PW'(i_stride);
          r_row <= w_nwin;
          r_col <= w_nwin;
        end
      end
    end
  end
endmodule

// File: rtl/pool_ctrl.sv
// pool_ctrl: max-pooling sequencer FSM with read, pool and write handshakes
module pool_ctrl import pool_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIDE_W-1:0] in_side,
  input  logic [KER_W-1:0]  kernel,
  input  logic [STR_W-1:0]  stride,
  input  logic [CH_W-1:0]   channels,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_req,
  output logic [AW-1:0]     rd_addr,
  input  logic              rd_ack,
  output logic              pool_start,
  output logic [LEN_W-1:0]  pool_len,
  input  logic              pool_done,
  input  logic [DW-1:0]     pool_result,
  output logic              wr_req,
  output logic [AW-1:0]     wr_addr,
  output logic [DW-1:0]     wr_data,
  input  logic              wr_ack
);
  state_t r_state, w_nx;
  logic [SIDE_W-1:0] r_side;
  logic [KER_W-1:0] r_k;
  logic [STR_W-1:0] r_s;
  logic [CH_W-1:0] r_ch;
  logic [AW-1:0] r_rp, r_wcnt;
  logic [LEN_W-1:0] r_len;
  logic [DW-1:0] r_wdata;
  logic r_err, r_last;
  logic w_bad, w_init, w_step, w_last_elem, w_last_win;
  assign w_bad = r_k == '0 || r_s == '0 || r_ch == '0 || SIDE_W'(r_k) > r_side;
  assign busy = r_state != S_IDLE && r_state != S_FIN;
  assign done = r_state == S_FIN;
  assign err = done & r_err;
  assign rd_req = r_state == S_READ;
  assign pool_start = r_state == S_START;
  assign wr_req = r_state == S_WRITE;
  assign pool_len = r_len;
  assign wr_addr = r_wcnt;
  assign wr_data = r_wdata;
  pool_addr_gen #(.AW(AW)) u_addr (
    .clk(clk), .rst(rst), .i_init(w_init), .i_step(w_step),
    .i_side(r_side), .i_kernel(r_k), .i_stride(r_s), .i_ch(r_ch), .i_rp(r_rp),
    .o_addr(rd_addr), .o_last_elem(w_last_elem), .o_last_win(w_last_win)
  );
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_nx;
  end
  // next state, address-generator init and per-ack step
  always_comb begin
    w_nx = r_state;
    w_init = 1'b0;
    w_step = 1'b0;
    case (r_state)
      S_IDLE:  w_nx = start ? S_SETUP : S_IDLE;
      S_SETUP: begin
        w_init = 1'b1;
        w_nx = w_bad ? S_FIN : S_START;
      end
      S_START: w_nx = S_READ;
      S_READ:  begin
        w_step = rd_ack;
        w_nx = rd_ack && w_last_elem ? S_WAIT : S_READ;
      end
      S_WAIT:  w_nx = pool_done ? S_WRITE : S_WAIT;
      S_WRITE: w_nx = wr_ack ? (r_last ? S_FIN : S_START) : S_WRITE;
      default: w_nx = S_IDLE;
    endcase
  end
  // latch configuration, derived sizes, last-window flag and window results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_side <= '0; r_k <= '0; r_s <= '0; r_ch <= '0;
      r_rp <= '0; r_len <= '0; r_err <= 1'b0; r_last <= 1'b0;
      r_wdata <= '0; r_wcnt <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_side <= in_side; r_k <= kernel; r_s <= stride; r_ch <= channels;
        r_wcnt <= '0;
      end
      if (r_state == S_SETUP) begin
        r_rp <= AW'(r_side) * AW'(r_ch);
        r_len <= LEN_W'(r_k) * LEN_W'(r_k);
        r_err <= w_bad;
      end
      if (w_step) r_last <= w_last_win;
      if (r_state == S_WAIT && pool_done) r_wdata <= pool_result;
      if (r_state == S_WRITE && wr_ack) r_wcnt <= r_wcnt + AW'(1);
    end
  end
endmodule

// File: tb/tb_pool_ctrl.sv
// tb_pool_ctrl: scoreboard bench with memory/pooling-unit responders and a loop-formula reference
module tb_pool_ctrl;
  logic clk, rst, start;
  logic [7:0] in_side;
  logic [3:0] kernel;
  logic [1:0] stride;
  logic [11:0] channels;
  logic busy, done, err, rd_req, rd_ack, pool_start, pool_done, wr_req, wr_ack;
  logic [23:0] rd_addr, wr_addr;
  logic [7:0] pool_len;
  logic [15:0] pool_result, wr_data;

  pool_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .in_side(in_side), .kernel(kernel),
    .stride(stride), .channels(channels), .busy(busy), .done(done), .err(err),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .pool_start(pool_start),
    .pool_len(pool_len), .pool_done(pool_done), .pool_result(pool_result),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] q_rd[$];
  logic [39:0] q_wr[$];
  bit q_done[$];
  int n_chk = 0, n_pass = 0;
  int n_ps = 0, n_rdreq = 0, n_wrreq = 0, done_cnt = 0;
  int rd_delay = 0, wr_delay = 0, r_dly = 0, w_dly = 0, r_cnt = 0, w_cnt = 0;
  int p_wait = 0, p_cnt = 0, exp_len = 0;
  logic [15:0] p_max;
  logic [23:0] r_hold, w_ha;
  logic [15:0] w_hd;
  bit rnd_dly = 0, noise = 0, spur_en = 0, after_wr = 0, after_pd = 0;

  function automatic logic [15:0] mem(input logic [23:0] a);
    logic [23:0] h;
    h = (a * 24'd40503) ^ (a >> 7) ^ 24'h0005a5;
    return h[15:0];
  endfunction

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // reference: enumerate windows and elements straight from the loop-nest address formula
  task automatic push_ref(input int side, input int k, input int s, input int ch);
    int nw, idx, a;
    logic [15:0] mx;
    exp_len = k * k;
    if (k == 0 || s == 0 || ch == 0 || k > side) begin
      q_done.push_back(1'b1);
      return;
    end
    nw = (side - k) / s + 1;
    idx = 0;
    for (int oy = 0; oy < nw; oy++)
      for (int ox = 0; ox < nw; ox++)
        for (int c = 0; c < ch; c++) begin
          mx = '0;
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
              a = ((oy * s + ky) * side + ox * s + kx) * ch + c;
              q_rd.push_back(24'(a));
              if (mem(24'(a)) > mx) mx = mem(24'(a));
            end
          q_wr.push_back({24'(idx), mx});
          idx++;
        end
    q_done.push_back(1'b0);
  endtask

  // monitor + memory and pooling-unit responders
  initial begin
    logic [23:0] ea;
    logic [39:0] ew;
    bit ee;
    rd_ack = 0; wr_ack = 0; pool_done = 0; pool_result = '0; p_max = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_ack = 0; wr_ack = 0; pool_done = 0;
        continue;
      end
      if (after_wr) begin
        check(pool_start || done, "wack_to_next", {pool_start, done}, 1);
        after_wr = 0;
      end
      if (after_pd) begin
        check(wr_req, "pdone_to_wreq", wr_req, 1);
        after_pd = 0;
      end
      pool_done = 0;
      if (p_wait > 0) begin
        p_wait--;
        if (p_wait == 0) begin
          pool_done = 1; pool_result = p_max; after_pd = 1;
        end
      end else if (spur_en && rd_req) begin
        pool_done = 1; pool_result = 16'hffff; spur_en = 0;
      end
      if (pool_start) begin
        n_ps++;
        check(pool_len == 8'(exp_len), "pool_len", pool_len, exp_len);
        p_cnt = 0; p_max = '0;
      end
      if (done) begin
        done_cnt++;
        check(!busy, "busy_at_done", busy, 0);
        check(q_done.size() != 0, "done_extra", done, 0);
        if (q_done.size() != 0) begin
          ee = q_done.pop_front();
          check(err == ee, "err", err, ee);
        end
      end
      rd_ack = 0;
      if (rd_req) begin
        n_rdreq++;
        if (r_cnt == 0) r_hold = rd_addr;
        else check(rd_addr == r_hold, "rd_hold", rd_addr, r_hold);
        if (r_cnt >= r_dly) begin
          rd_ack = 1; r_cnt = 0;
          r_dly = rnd_dly ? int'($urandom_range(0, 2)) : rd_delay;
          check(q_rd.size() != 0, "rd_extra", rd_addr, 0);
          if (q_rd.size() != 0) begin
            ea = q_rd.pop_front();
            check(rd_addr == ea, "rd_addr", rd_addr, ea);
          end
          if (mem(rd_addr) > p_max) p_max = mem(rd_addr);
          p_cnt++;
          if (p_cnt == exp_len) p_wait = 1 + int'($urandom_range(0, 3));
        end else r_cnt++;
      end else rd_ack = noise && ($urandom_range(0, 3) == 0);
      wr_ack = 0;
      if (wr_req) begin
        n_wrreq++;
        if (w_cnt == 0) begin
          w_ha = wr_addr; w_hd = wr_data;
        end else check(wr_addr == w_ha && wr_data == w_hd, "wr_hold", {wr_addr, wr_data}, {w_ha, w_hd});
        if (w_cnt >= w_dly) begin
          wr_ack = 1; w_cnt = 0; after_wr = 1;
          w_dly = rnd_dly ? int'($urandom_range(0, 3)) : wr_delay;
          check(q_wr.size() != 0, "wr_extra", {wr_addr, wr_data}, 0);
          if (q_wr.size() != 0) begin
            ew = q_wr.pop_front();
            check({wr_addr, wr_data} == ew, "wr", {wr_addr, wr_data}, ew);
          end
        end else w_cnt++;
      end
    end
  end

  task automatic start_job(input int side, input int k, input int s, input int ch, output int d0);
    push_ref(side, k, s, ch);
    d0 = done_cnt;
    r_cnt = 0; w_cnt = 0;
    r_dly = rnd_dly ? int'($urandom_range(0, 2)) : rd_delay;
    w_dly = rnd_dly ? int'($urandom_range(0, 3)) : wr_delay;
    in_side = 8'(side); kernel = 4'(k); stride = 2'(s); channels = 12'(ch);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int d0, input bit mid);
    bit did;
    did = 0;
    for (int i = 0; i < 20000 && done_cnt == d0; i++) begin
      @(negedge clk);
      if (start) start = 0;
      else if (mid && rd_req && !did) begin
        start = 1; in_side = 8'd3; kernel = 4'd1; stride = 2'd1; channels = 12'd1; did = 1;
      end
    end
    start = 0;
    check(done_cnt != d0, "done_timeout", done_cnt, d0 + 1);
    @(negedge clk);
  endtask

  task automatic timed_job(input int side, input int k, input int s, input int ch);
    int d0;
    start_job(side, k, s, ch, d0);
    check(busy && !pool_start, "busy_t1", {busy, pool_start}, 2'b10);
    @(negedge clk);
    check(pool_start && !rd_req, "pstart_t2", {pool_start, rd_req}, 2'b10);
    @(negedge clk);
    check(rd_req, "rdreq_t3", rd_req, 1);
    wait_done(d0, 0);
  endtask

  task automatic bad_job(input int side, input int k, input int s, input int ch);
    int d0, ps0, rq0, wq0;
    ps0 = n_ps; rq0 = n_rdreq; wq0 = n_wrreq;
    start_job(side, k, s, ch, d0);
    check(busy && !done, "bad_t1", {busy, done}, 2'b10);
    @(negedge clk);
    check(done && err, "bad_done_t2", {done, err}, 2'b11);
    @(negedge clk);
    check(n_ps == ps0 && n_rdreq == rq0 && n_wrreq == wq0, "bad_no_traffic",
          (n_ps - ps0) + (n_rdreq - rq0) + (n_wrreq - wq0), 0);
    check(done_cnt == d0 + 1, "bad_done_once", done_cnt - d0, 1);
  endtask

  task automatic reset_mid();
    int d0, ps0;
    ps0 = n_ps;
    start_job(4, 2, 2, 1, d0);
    for (int i = 0; i < 2000 && !(n_ps - ps0 >= 2 && rd_req); i++) @(negedge clk);
    check(n_ps - ps0 >= 2 && rd_req, "rst_reach_win2", n_ps - ps0, 2);
    rst = 1;
    #1;
    check(!busy && !done && !err && !rd_req && !pool_start && !wr_req, "rst_ctl_zero",
          {busy, done, err, rd_req, pool_start, wr_req}, 0);
    check(rd_addr == 0 && wr_addr == 0 && wr_data == 0 && pool_len == 0, "rst_data_zero",
          {rd_addr, wr_addr}, 0);
    q_rd.delete(); q_wr.delete(); q_done.delete();
    p_wait = 0; p_cnt = 0; r_cnt = 0; w_cnt = 0; after_wr = 0; after_pd = 0; spur_en = 0;
    rd_ack = 0; wr_ack = 0; pool_done = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    check(done_cnt == d0 && !busy, "rst_no_done", done_cnt - d0, 0);
  endtask

  initial begin
    int side, k, s, ch, d0;
    rst = 1; start = 0; in_side = '0; kernel = '0; stride = '0; channels = '0;
    repeat (3) @(negedge clk);
    check(!busy && !done && !err && !rd_req && !pool_start && !wr_req, "reset_ctl",
          {busy, done, err, rd_req, pool_start, wr_req}, 0);
    check(rd_addr == 0 && wr_addr == 0 && wr_data == 0 && pool_len == 0, "reset_data",
          {rd_addr, wr_addr}, 0);
    rst = 0;
    @(negedge clk);
    timed_job(4, 2, 2, 1);
    timed_job(4, 3, 1, 2);
    rd_delay = 3; wr_delay = 5;
    timed_job(4, 3, 1, 2);
    rd_delay = 0; wr_delay = 0;
    bad_job(4, 5, 1, 1);
    bad_job(4, 2, 1, 0);
    bad_job(4, 2, 0, 1);
    noise = 1; spur_en = 1;
    start_job(5, 2, 1, 3, d0);
    wait_done(d0, 1);
    check(!spur_en, "spur_issued", spur_en, 0);
    rnd_dly = 1;
    for (int j = 0; j < 4; j++) begin
      side = int'($urandom_range(1, 7));
      k = int'($urandom_range(1, side < 4 ? side : 4));
      s = int'($urandom_range(1, 3));
      ch = int'($urandom_range(1, 2));
      timed_job(side, k, s, ch);
    end
    rnd_dly = 0; noise = 0;
    reset_mid();
    timed_job(4, 2, 2, 1);
    check(q_rd.size() == 0 && q_wr.size() == 0 && q_done.size() == 0, "queues_drained",
          q_rd.size() + q_wr.size() + q_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
